suprloco_rom_bus_ctrl: RTL



---
 rtl/suprloco_rom_bus_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/suprloco_rom_bus_ctrl.sv
// suprloco_rom_bus_ctrl: shares the program-ROM port between Z80 reads and one-deep loader writes
module suprloco_rom_bus_ctrl #(
    parameter logic [15:0] ROM_TOP = 16'hBFFF,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        i_CLK,
    input  logic        i_RST_n,
    input  logic        i_CPU_MREQ_n,
    input  logic        i_CPU_RD_n,
    input  logic        i_CPU_RFSH_n,
    input  logic [15:0] i_CPU_ADDR,
    output logic        o_CPU_WAIT_n,
    output logic [7:0]  o_CPU_DI,
    input  logic        i_DL_WR,
    input  logic [15:0] i_DL_ADDR,
    input  logic [7:0]  i_DL_DATA,
    output logic        o_DL_BUSY,
    output logic        o_MEM_REQ,
    output logic        o_MEM_WE,
    output logic [15:0] o_MEM_ADDR,
    output logic [7:0]  o_MEM_DO,
    input  logic        i_MEM_ACK,
    input  logic [7:0]  i_MEM_DI,
    output logic        o_ERR
);
    localparam logic [1:0] S_IDLE = 2'd0, S_CPU_REQ = 2'd1, S_CPU_DONE = 2'd2, S_DL_REQ = 2'd3;
    logic [1:0]  r_state;
    logic        r_rd_cond_q, r_rd_miss, r_dl_pend;
    logic [15:0] r_dl_addr;
    logic [7:0]  r_dl_data, r_timer;
    logic        w_rd_cond, w_rd_start, w_rd_go, w_tmo_hit, w_done;
    assign w_rd_cond  = ~i_CPU_MREQ_n & ~i_CPU_RD_n & i_CPU_RFSH_n & (i_CPU_ADDR <= ROM_TOP);
    assign w_rd_start = w_rd_cond & ~r_rd_cond_q;
    // a read edge seen while a loader write is in flight is remembered so the CPU is not left stalled
    assign w_rd_go    = w_rd_cond & (w_rd_start | r_rd_miss);
    assign w_tmo_hit  = r_timer == TIMEOUT;
    assign w_done     = i_MEM_ACK | w_tmo_hit;
    assign o_CPU_WAIT_n = ~i_RST_n | ~(w_rd_cond & (r_state != S_CPU_DONE));
    assign o_DL_BUSY    = r_dl_pend | (r_state == S_DL_REQ);
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state     <= S_IDLE;
            r_rd_cond_q <= 1'b0;
            r_rd_miss   <= 1'b0;
            r_dl_pend   <= 1'b0;
            r_dl_addr   <= 16'h0;
            r_dl_data   <= 8'h0;
            r_timer     <= 8'h0;
            o_CPU_DI    <= 8'hFF;
            o_MEM_REQ   <= 1'b0;
            o_MEM_WE    <= 1'b0;
            o_MEM_ADDR  <= 16'h0;
            o_MEM_DO    <= 8'h0;
            o_ERR       <= 1'b0;
        end else begin
            r_rd_cond_q <= w_rd_cond;
            r_rd_miss   <= (r_state == S_IDLE || !w_rd_cond) ? 1'b0 : (r_rd_miss | w_rd_start);
            r_timer     <= r_timer + 8'd1;
            if (i_DL_WR) begin
                if (o_DL_BUSY) begin
                    o_ERR <= 1'b1;
                end else begin
                    r_dl_pend <= 1'b1;
                    r_dl_addr <= i_DL_ADDR;
                    r_dl_data <= i_DL_DATA;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rd_go) begin
                        r_state    <= S_CPU_REQ;
                        o_MEM_ADDR <= i_CPU_ADDR;
                        o_MEM_WE   <= 1'b0;
                        o_MEM_REQ  <= 1'b1;
                        r_timer    <= 8'h0;
                    end else if (r_dl_pend) begin
                        r_state    <= S_DL_REQ;
                        o_MEM_ADDR <= r_dl_addr;
                        o_MEM_DO   <= r_dl_data;
                        o_MEM_WE   <= 1'b1;
                        o_MEM_REQ  <= 1'b1;
                        r_timer    <= 8'h0;
                    end
                end
                S_CPU_REQ: begin
                    if (w_done) begin
                        o_CPU_DI  <= i_MEM_ACK ? i_MEM_DI : 8'hFF;
                        o_MEM_REQ <= 1'b0;
                        o_ERR     <= o_ERR | ~i_MEM_ACK;
                        r_state   <= w_rd_cond ? S_CPU_DONE : S_IDLE;
                    end
                end
                S_CPU_DONE: begin
                    if (!w_rd_cond) r_state <= S_IDLE;
                end
                default: begin
                    if (w_done) begin
                        o_MEM_REQ <= 1'b0;
                        o_MEM_WE  <= 1'b0;
                        r_dl_pend <= 1'b0;
                        o_ERR     <= o_ERR | ~i_MEM_ACK;
                        r_state   <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
